// File: rtl/mbist_addr_gen.sv
// MBIST address sequencer: linear bounded or row-fast full-array sweeps,
// either direction, with completion, abort and illegal-start reporting.
module mbist_addr_gen #(
    parameter int ADDR_W = 10,
    parameter int ROW_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              adv,
    input  logic              u_d,
    input  logic              mode,
    input  logic [ADDR_W-1:0] addr_lo,
    input  logic [ADDR_W-1:0] addr_hi,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              last,
    output logic              done,
    output logic              err
);

    localparam int COL_W = ADDR_W - ROW_W;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic              up_q, up_d;
    logic              mode_q, mode_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] addr_step;
    logic              at_end;

    assign row    = addr_q[ADDR_W-1:COL_W];
    assign col    = addr_q[COL_W-1:0];
    assign at_end = (addr_q == end_q);

    // Row-fast: the row field moves every step, the column only on row wrap.
    always_comb begin
        addr_step = addr_q;
        if (!mode_q) begin
            addr_step = up_q ? addr_q + ADDR_W'(1) : addr_q - ADDR_W'(1);
        end else if (up_q) begin
            if (&row) addr_step = {{ROW_W{1'b0}}, col + COL_W'(1)};
            else      addr_step = {row + ROW_W'(1), col};
        end else begin
            if (~|row) addr_step = {{ROW_W{1'b1}}, col - COL_W'(1)};
            else       addr_step = {row - ROW_W'(1), col};
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        end_d   = end_q;
        up_d    = up_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    if (!mode && (addr_lo > addr_hi)) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        up_d    = u_d;
                        mode_d  = mode;
                        if (mode) begin
                            addr_d = u_d ? {ADDR_W{1'b0}} : {ADDR_W{1'b1}};
                            end_d  = u_d ? {ADDR_W{1'b1}} : {ADDR_W{1'b0}};
                        end else begin
                            addr_d = u_d ? addr_lo : addr_hi;
                            end_d  = u_d ? addr_hi : addr_lo;
                        end
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (adv) begin
                    if (at_end) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_step;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            end_q   <= '0;
            up_q    <= 1'b0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            up_q    <= up_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign addr = addr_q;
    assign busy = (state_q == RUN);
    assign last = busy && at_end;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mbist_addr_gen.sv
// Self-checking bench for mbist_addr_gen at ADDR_W=4, ROW_W=2: vector table
// plus row-fast sweeps and an asynchronous mid-sweep reset.
module tb_mbist_addr_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0, adv = 1'b0, u_d = 1'b0, mode = 1'b0;
    logic [3:0] addr_lo = '0, addr_hi = '0;
    logic [3:0] addr;
    logic       busy, last, done, err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       start, abort, adv, u_d, mode;
        logic [3:0] lo, hi;
        logic [7:0] exp;   // {addr, busy, last, done, err}
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] sb[$];

    mbist_addr_gen #(.ADDR_W(4), .ROW_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .adv(adv),
        .u_d(u_d), .mode(mode), .addr_lo(addr_lo), .addr_hi(addr_hi),
        .addr(addr), .busy(busy), .last(last), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic ab, input logic ad,
                                input logic ud, input logic md,
                                input logic [3:0] lo, input logic [3:0] hi,
                                input logic [3:0] ea, input logic eb,
                                input logic el, input logic ed, input logic ee);
        vec_t v;
        v.start = s; v.abort = ab; v.adv = ad; v.u_d = ud; v.mode = md;
        v.lo = lo; v.hi = hi;
        v.exp = {ea, eb, el, ed, ee};
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got addr=%h busy=%b last=%b done=%b err=%b, want addr=%h busy=%b last=%b done=%b err=%b",
                     name, got[7:4], got[3], got[2], got[1], got[0],
                     exp[7:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        logic [7:0] e;
        @(negedge clk);
        start = v.start; abort = v.abort; adv = v.adv; u_d = v.u_d; mode = v.mode;
        addr_lo = v.lo; addr_hi = v.hi;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(name, {addr, busy, last, done, err}, e);
    endtask

    initial begin
        vec_t v;
        int   k;
        logic [3:0] ea;

        // linear up 3..6
        tbl.push_back(mk(1,0,0,1,0, 4'd3,4'd6, 4'd3,1,0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 4'd3,4'd6, 4'd4,1,0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 4'd3,4'd6, 4'd5,1,0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 4'd3,4'd6, 4'd6,1,1,0,0));
        tbl.push_back(mk(0,0,1,1,0, 4'd3,4'd6, 4'd6,0,0,1,0));
        tbl.push_back(mk(0,0,0,1,0, 4'd3,4'd6, 4'd6,0,0,0,0));
        // linear down 6..3
        tbl.push_back(mk(1,0,0,0,0, 4'd3,4'd6, 4'd6,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 4'd3,4'd6, 4'd5,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 4'd3,4'd6, 4'd4,1,0,0,0));
        tbl.push_back(mk(0,0,1,0,0, 4'd3,4'd6, 4'd3,1,1,0,0));
        tbl.push_back(mk(0,0,1,0,0, 4'd3,4'd6, 4'd3,0,0,1,0));
        // single-address sweep, then illegal start, then adv in IDLE
        tbl.push_back(mk(1,0,0,1,0, 4'd9,4'd9, 4'd9,1,1,0,0));
        tbl.push_back(mk(0,0,1,1,0, 4'd9,4'd9, 4'd9,0,0,1,0));
        tbl.push_back(mk(1,0,0,1,0, 4'd7,4'd2, 4'd9,0,0,0,1));
        tbl.push_back(mk(0,0,0,1,0, 4'd7,4'd2, 4'd9,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,0, 4'd7,4'd2, 4'd9,0,0,0,0));
        tbl.push_back(mk(0,0,1,1,0, 4'd0,4'd15, 4'd9,0,0,0,0));
        // abort at 5 together with adv
        tbl.push_back(mk(1,0,0,1,0, 4'd0,4'd15, 4'd0,1,0,0,0));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0,0,1,1,0, 4'd0,4'd15, 4'(i),1,0,0,0));
        tbl.push_back(mk(0,1,1,1,0, 4'd0,4'd15, 4'd5,0,0,0,0));
        tbl.push_back(mk(1,1,0,1,0, 4'd3,4'd6, 4'd5,0,0,0,0));
        // start during RUN is ignored
        tbl.push_back(mk(1,0,0,1,0, 4'd3,4'd6, 4'd3,1,0,0,0));
        tbl.push_back(mk(1,0,0,0,0, 4'd10,4'd12, 4'd3,1,0,0,0));
        tbl.push_back(mk(0,1,0,0,0, 4'd10,4'd12, 4'd3,0,0,0,0));

        #1;
        check("reset_in", {addr, busy, last, done, err}, 8'h00);
        #12 rst_n = 1'b1;
        check("reset_out", {addr, busy, last, done, err}, 8'h00);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // row-fast up: column index k/4 in low bits, row k%4 in high bits
        for (k = 0; k < 16; k++) begin
            ea = 4'((k / 4) | ((k % 4) << 2));
            v = mk(k == 0, 0, k != 0, 1, 1, 4'd7, 4'd2, ea, 1, k == 15, 0, 0);
            apply(v, $sformatf("rf_up%0d", k));
        end
        apply(mk(0,0,1,1,1, 4'd7,4'd2, 4'hF,0,0,1,0), "rf_up_done");

        // row-fast down: mirror image of the ascending order
        for (k = 0; k < 16; k++) begin
            ea = 4'(15 - ((k / 4) | ((k % 4) << 2)));
            v = mk(k == 0, 0, k != 0, 0, 1, 4'd7, 4'd2, ea, 1, k == 15, 0, 0);
            apply(v, $sformatf("rf_dn%0d", k));
        end
        apply(mk(0,0,1,0,1, 4'd7,4'd2, 4'h0,0,0,1,0), "rf_dn_done");

        // asynchronous reset between edges, mid-sweep
        apply(mk(1,0,0,1,0, 4'd2,4'd12, 4'd2,1,0,0,0), "pre_rst0");
        apply(mk(0,0,1,1,0, 4'd2,4'd12, 4'd3,1,0,0,0), "pre_rst1");
        @(negedge clk);
        start = 0; adv = 0; abort = 0;
        #1 rst_n = 1'b0;
        #2 check("async_rst", {addr, busy, last, done, err}, 8'h00);
        rst_n = 1'b1;
        apply(mk(1,0,0,1,0, 4'd3,4'd6, 4'd3,1,0,0,0), "post_rst");
        apply(mk(0,0,1,1,0, 4'd3,4'd6, 4'd4,1,0,0,0), "post_rst_adv");

        // reset while done is pulsing
        apply(mk(0,0,1,1,0, 4'd3,4'd6, 4'd5,1,0,0,0), "d_a");
        apply(mk(0,0,1,1,0, 4'd3,4'd6, 4'd6,1,1,0,0), "d_b");
        apply(mk(0,0,1,1,0, 4'd3,4'd6, 4'd6,0,0,1,0), "d_c");
        #1 rst_n = 1'b0;
        #2 check("rst_done", {addr, busy, last, done, err}, 8'h00);
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: sim time exceeded bound");
        $fatal(1);
    end

endmodule
